// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low glyph table, segment bit indices
// and the capture FSM state type.
package sseg_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry n is the active-low {g..a} pattern for hex digit n.
   localparam logic [15:0][6:0] GLYPH_TBL = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic {SETTLING, HOLD} state_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational inverse of the display encoder: active-low segment pattern to
// hex nibble, with a hit flag for recognised glyphs.
module sseg_glyph_decode
   import sseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nib,
   output logic       hit
);

   always_comb begin
      nib = 4'h0;
      hit = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == GLYPH_TBL[i]) begin
            nib = 4'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sseg_capture.sv
// Samples a multiplexed active-low seven-segment bus, decodes each settled slot
// and publishes a 16-bit value once all four digits of a frame are collected.
//
// state    | meaning
// SETTLING | inputs changed recently; counting stable cycles toward SETTLE
// HOLD     | current slot already sampled; wait for the next input change
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sseg_an,
   input  logic [7:0]  sseg_sig,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic        valid,
   output logic        frame_done,
   output logic        glyph_err,
   output logic        an_err
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   logic [3:0]       an_q;
   logic [7:0]       sig_q;
   logic [7:0]       cnt;
   state_t           state;
   logic             chg;
   logic             sample;
   logic [3:0]       an_low;
   logic             one_an;
   logic             multi_an;
   logic [1:0]       idx;
   logic [3:0]       nib;
   logic             hit;
   logic [3:0]       seen;
   logic [3:0][3:0]  shadow;
   logic [3:0]       dp_shadow;
   logic             commit;

   sseg_glyph_decode u_dec (
      .seg (sig_q[SEG_G:SEG_A]),
      .nib (nib),
      .hit (hit)
   );

   // A change seen at the input register resets the count on the same edge it is registered.
   assign chg      = ({sseg_an, sseg_sig} != {an_q, sig_q});
   assign sample   = (state == SETTLING) && !chg && (cnt == SETTLE_C - 8'd1);
   assign an_low   = ~an_q;
   assign one_an   = $onehot(an_low);
   assign multi_an = !one_an && (an_low != 4'h0);

   always_comb begin
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (an_low[i]) idx = 2'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an_q  <= 4'hF;
         sig_q <= 8'hFF;
         cnt   <= 8'd0;
         state <= SETTLING;
      end else begin
         an_q  <= sseg_an;
         sig_q <= sseg_sig;
         if (chg) begin
            cnt   <= 8'd0;
            state <= SETTLING;
         end else begin
            if (cnt != SETTLE_C) cnt <= cnt + 8'd1;
            if (sample) state <= HOLD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow     <= '0;
         dp_shadow  <= 4'h0;
         seen       <= 4'h0;
         commit     <= 1'b0;
         value      <= 16'h0000;
         dp         <= 4'h0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         glyph_err  <= 1'b0;
         an_err     <= 1'b0;
      end else begin
         commit     <= 1'b0;
         frame_done <= commit;
         glyph_err  <= 1'b0;
         an_err     <= 1'b0;
         // Shadows already hold the completing digit by the time commit is seen.
         if (commit) begin
            value <= shadow;
            dp    <= dp_shadow;
            valid <= 1'b1;
            seen  <= 4'h0;
         end
         if (sample) begin
            if (multi_an) begin
               an_err <= 1'b1;
            end else if (one_an) begin
               if (hit) begin
                  shadow[idx]    <= nib;
                  dp_shadow[idx] <= ~sig_q[SEG_DP];
                  seen[idx]      <= 1'b1;
                  commit         <= ((seen | (4'b0001 << idx)) == 4'hF);
               end else begin
                  glyph_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sseg_capture.sv
// Directed self-checking bench for sseg_capture with SETTLE=4.
module tb_sseg_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  sseg_an = 4'hF;
   logic [7:0]  sseg_sig = 8'hFF;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        valid;
   logic        frame_done;
   logic        glyph_err;
   logic        an_err;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;
   int ge_cnt = 0;
   int ae_cnt = 0;
   int fd0, ge0, ae0;

   sseg_capture #(.SETTLE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .sseg_an    (sseg_an),
      .sseg_sig   (sseg_sig),
      .value      (value),
      .dp         (dp),
      .valid      (valid),
      .frame_done (frame_done),
      .glyph_err  (glyph_err),
      .an_err     (an_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (glyph_err)  ge_cnt++;
      if (an_err)     ae_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slot(input logic [3:0] an, input logic [7:0] sig, input int n);
      @(negedge clk);
      sseg_an  = an;
      sseg_sig = sig;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic idle();
      slot(4'hF, 8'hFF, 8);
   endtask

   task automatic snap();
      fd0 = fd_cnt;
      ge0 = ge_cnt;
      ae0 = ae_cnt;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_pulses", 32'({frame_done, glyph_err, an_err}), 32'h0);
      rst = 1'b1;
      idle();

      // frame 1,2,3,4 with exact frame_done timing on the last digit
      snap();
      slot(4'b1110, 8'hF9, 8);
      slot(4'b1101, 8'hA4, 8);
      slot(4'b1011, 8'hB0, 8);
      @(negedge clk);
      sseg_an  = 4'b0111;
      sseg_sig = 8'h99;
      repeat (5) @(negedge clk);
      chk("fd_early", 32'(frame_done), 32'h0);
      chk("valid_early", 32'(valid), 32'h0);
      @(negedge clk);
      chk("fd_edge", 32'(frame_done), 32'h1);
      chk("value_edge", 32'(value), 32'h4321);
      repeat (2) @(negedge clk);
      idle();
      chk("f1_fd_count", 32'(fd_cnt - fd0), 32'd1);
      chk("f1_value", 32'(value), 32'h4321);
      chk("f1_valid", 32'(valid), 32'h1);
      chk("f1_dp", 32'(dp), 32'h0);

      // decimal point on digit 0 only
      snap();
      slot(4'b1110, 8'h00, 8);
      slot(4'b1101, 8'h80, 8);
      slot(4'b1011, 8'h80, 8);
      slot(4'b0111, 8'h80, 8);
      idle();
      chk("f2_fd_count", 32'(fd_cnt - fd0), 32'd1);
      chk("f2_value", 32'(value), 32'h8888);
      chk("f2_dp", 32'(dp), 32'h1);

      // short slot for digit 0 is ignored, so digits 1-3 alone do not complete
      snap();
      slot(4'b1110, 8'hF9, 4);
      idle();
      slot(4'b1101, 8'hF8, 8);
      slot(4'b1011, 8'hF8, 8);
      slot(4'b0111, 8'hF8, 8);
      idle();
      chk("short_fd_count", 32'(fd_cnt - fd0), 32'd0);
      chk("short_value", 32'(value), 32'h8888);
      slot(4'b1110, 8'h92, 8);
      idle();
      chk("short_fd_after", 32'(fd_cnt - fd0), 32'd1);
      chk("short_value_after", 32'(value), 32'h7775);
      chk("short_dp_after", 32'(dp), 32'h0);

      // anode and glyph errors
      snap();
      slot(4'b1100, 8'hF9, 8);
      idle();
      chk("an_err_count", 32'(ae_cnt - ae0), 32'd1);
      chk("an_err_no_ge", 32'(ge_cnt - ge0), 32'd0);
      slot(4'b1110, 8'h7F, 8);
      idle();
      chk("glyph_err_count", 32'(ge_cnt - ge0), 32'd1);
      chk("err_value", 32'(value), 32'h7775);
      chk("err_fd_count", 32'(fd_cnt - fd0), 32'd0);

      // digit 0 overwritten before the frame completes
      snap();
      slot(4'b1110, 8'h92, 8);
      slot(4'b1110, 8'h82, 8);
      slot(4'b1101, 8'hF9, 8);
      slot(4'b1011, 8'hA4, 8);
      slot(4'b0111, 8'hB0, 8);
      idle();
      chk("ovw_fd_count", 32'(fd_cnt - fd0), 32'd1);
      chk("ovw_value", 32'(value), 32'h3216);

      // reset discards a partial frame; stale digits 0,1 must not complete it
      slot(4'b1110, 8'hF9, 8);
      slot(4'b1101, 8'hA4, 8);
      @(negedge clk);
      sseg_an  = 4'hF;
      sseg_sig = 8'hFF;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst2_value", 32'(value), 32'h0);
      chk("rst2_valid", 32'(valid), 32'h0);
      idle();
      snap();
      slot(4'b1011, 8'hC6, 8);
      slot(4'b0111, 8'hA1, 8);
      idle();
      chk("rst2_no_stale", 32'(fd_cnt - fd0), 32'd0);
      slot(4'b1110, 8'h88, 8);
      slot(4'b1101, 8'h83, 8);
      idle();
      chk("rst2_fd_count", 32'(fd_cnt - fd0), 32'd1);
      chk("rst2_frame", 32'(value), 32'hDCBA);
      chk("rst2_valid_set", 32'(valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receive-side counterpart of the multiplexed seven-segment driver. Samples the time-multiplexed anode and segment bus (active-low, Nexys3 pinout), waits for each anode slot to settle, and decodes the glyph back to a hex nibble. Once all four digits of a frame are collected, it presents the reconstructed 16-bit value. Used for loopback self-test and as a bench/board monitor of the display path.

## Interface
- SETTLE, default 4: consecutive unchanged cycles required before a slot is sampled; legal range 1–255.
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- sseg_an  in  4  anode enables, active-low; bit i low selects digit i.
- sseg_sig  in  8  segments, active-low: [0]=a … [6]=g, [7]=dp.
- value  out  16  captured frame: digit i in value[4i+3:4i]; reset 16'h0000.
- dp  out  4  captured decimal points, 1 = lit; reset 4'h0.
- valid  out  1  sticky; set by the first completed frame; reset 0.
- frame_done  out  1  one-cycle pulse per completed frame; reset 0.
- glyph_err  out  1  one-cycle pulse: sampled segment pattern is not a hex glyph; reset 0.
- an_err  out  1  one-cycle pulse: more than one anode low at sample; reset 0.

## Operation
- Inputs registered once: in_q = {sseg_an, sseg_sig}.
- Stability counter cnt (8 bit):
  - In_q differs from its previous value → cnt=0.
  - Otherwise cnt increments, saturating at SETTLE.
- FSM, reset state SETTLING:
  - SETTLING → HOLD when cnt reaches SETTLE with no change. That edge is the sample edge.
  - HOLD → SETTLING on any change of in_q, with cnt=0.
  - Exactly one sample per stable slot.
- At the sample edge:
  - All anodes high (blank): no action, no error.
  - Two or more anodes low: an_err pulses; nothing captured.
  - Exactly one anode low (index i), segment low 7 bits a hex glyph (0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E):
    - Store the nibble in shadow[i] and ~sig[7] in dp_shadow[i].
    - Set seen[i].
  - Anode valid but glyph unknown (including all segments off): glyph_err pulses; shadow[i] and seen[i] are unchanged.
- Repeat of an already-seen digit before the frame completes: shadow[i] is overwritten with the newer glyph; seen is unchanged.
- When the capture makes seen == 4'b1111, on the next edge:
  - value and dp load all shadows atomically.
  - frame_done pulses, valid sets.
  - seen clears.
- value and dp are otherwise stable; a partial frame never alters them.
- rst low at any time: all registers return to reset values, FSM goes to SETTLING, seen=0, shadows=0. Any partial frame is discarded.

## Timing
- A pattern first visible on the inputs before edge k is registered at edge k.
- If the pattern is held, the sample edge is k+SETTLE. Error pulses and the shadow/seen update occur on that edge.
- frame_done, value and dp update at (sample edge of the completing digit)+1.
- Minimum slot length for capture: SETTLE+1 cycles. Shorter slots are silently ignored.
- Error pulses are exactly one cycle wide.
- frame_done and an error pulse never coincide for the same sample.

## Structure
- Shared package sseg_pkg holds:
  - the 16-entry active-low glyph constant table (shared with the driver's encoder);
  - segment bit-index constants;
  - the FSM state typedef {SETTLING, HOLD}.
- Sub-module sseg_glyph_decode (combinational): 7-bit pattern in → nibble + hit flag out. It is the inverse of the driver's glyph encoder.
- Top level contains the input register, stability counter, FSM, shadows and frame logic.

## Test plan
- Reset release, SETTLE=4. Drive anodes 1110/1101/1011/0111, each held 8 cycles with glyphs 1,2,3,4 → single frame_done; value=16'h4321, valid=1, dp=0.
- Anode 1110 with sig=8'h00 held 8 cycles (8 with dp lit), then the other three digits with sig=8'h80 (8, dp off) → value=16'h8888, dp=4'b0001.
- Slot held only 4 cycles with SETTLE=4 → no capture; seen unchanged; no frame_done.
- Anode 1100 held 8 cycles → an_err pulses once. Then anode 1110 with sig=8'h7F (blank) → glyph_err pulses once; value unchanged.
- Digit 0 captured as 5, then digit 0 re-sent as 6, then digits 1–3 → frame_done once; value[3:0]=6.
- Two digits captured, then rst low for 1 cycle, then a full frame A,b,C,d → value=16'hDCBA. The frame completes only after all four post-reset digits, with no stale-digit mix.
